// File: rtl/svm_window_scheduler.sv
// Frame sequencer for the SVM delay-line chain: tracks cell position, drives the
// line delays with registered enables, clears them between frames, emits window strobes.
module svm_window_scheduler #(
  parameter int H_SIZE     = 152,
  parameter int V_SIZE     = 60,
  parameter int WIN_W      = 8,
  parameter int WIN_H      = 4,
  parameter int DATA_WIDTH = 32,
  localparam int XW = $clog2(H_SIZE),
  localparam int YW = $clog2(V_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cell_valid,
  input  logic                  cell_sof,
  input  logic [DATA_WIDTH-1:0] cell_data,
  output logic [DATA_WIDTH-1:0] dl_din,
  output logic                  dl_en,
  output logic                  dl_rst,
  output logic                  win_valid,
  output logic [XW-1:0]         win_x,
  output logic [YW-1:0]         win_y,
  output logic                  frame_done,
  output logic                  sync_err,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  // Handshake: cell_valid has no ready. The source is never stalled; a valid
  // cell is either accepted or dropped in the very cycle it is presented.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic [XW-1:0] COL_LAST = XW'(H_SIZE - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(V_SIZE - 1);
  localparam logic [XW-1:0] X_MIN    = XW'(WIN_W - 1);
  localparam logic [YW-1:0] Y_MIN    = YW'(WIN_H - 1);

  state_t                r_state;
  logic [XW-1:0]         r_col;
  logic [YW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_dl_din;
  logic                  r_dl_en;
  logic                  r_win_p;
  logic [XW-1:0]         r_wx_p;
  logic [YW-1:0]         r_wy_p;
  logic                  r_last_p;
  logic                  r_win_valid;
  logic [XW-1:0]         r_win_x;
  logic [YW-1:0]         r_win_y;
  logic                  r_frame_done;
  logic                  r_sync_err;

  logic                  w_in_frame;
  logic                  w_accept;
  logic                  w_sync;
  logic                  w_col_last;
  logic                  w_last;
  logic                  w_win;
  logic [XW-1:0]         w_col_nxt;
  logic [YW-1:0]         w_row_nxt;

  // The counters always hold the position of the next cell, so the sof cell
  // taken in IDLE lands on (0,0) without a special case.
  assign w_in_frame = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_accept   = cell_valid && (((r_state == S_IDLE) && cell_sof) ||
                                     (w_in_frame && !cell_sof));
  assign w_sync     = cell_valid && cell_sof && w_in_frame;
  assign w_col_last = (r_col == COL_LAST);
  assign w_last     = w_accept && w_col_last && (r_row == ROW_LAST);
  assign w_win      = w_accept && (r_col >= X_MIN) && (r_row >= Y_MIN);
  assign w_col_nxt  = w_col_last ? '0 : r_col + XW'(1);
  assign w_row_nxt  = w_col_last ? r_row + YW'(1) : r_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_dl_din     <= '0;
      r_dl_en      <= 1'b0;
      r_win_p      <= 1'b0;
      r_wx_p       <= '0;
      r_wy_p       <= '0;
      r_last_p     <= 1'b0;
      r_win_valid  <= 1'b0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_dl_en <= w_accept;
      if (w_accept) r_dl_din <= cell_data;

      // Two-stage strobe pipe lines up with the delay line's read latency.
      r_win_p  <= w_win;
      r_last_p <= w_last;
      if (w_win) begin
        r_wx_p <= r_col - X_MIN;
        r_wy_p <= r_row - Y_MIN;
      end
      r_win_valid  <= r_win_p;
      r_frame_done <= r_last_p;
      if (r_win_p) begin
        r_win_x <= r_wx_p;
        r_win_y <= r_wy_p;
      end
      r_sync_err <= w_sync;

      case (r_state)
        S_IDLE, S_FILL, S_RUN: begin
          if (w_sync) begin
            r_state <= S_CLEAR;
            r_col   <= '0;
            r_row   <= '0;
          end else if (w_last) begin
            r_state <= S_FLUSH;
            r_col   <= '0;
            r_row   <= '0;
          end else if (w_accept) begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_state <= (w_row_nxt < Y_MIN) ? S_FILL : S_RUN;
          end
        end
        S_FLUSH: r_state <= S_CLEAR;
        S_CLEAR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dl_din     = r_dl_din;
  assign dl_en      = r_dl_en;
  assign dl_rst     = (r_state == S_CLEAR);
  assign win_valid  = r_win_valid;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_svm_window_scheduler.sv
// Randomized bench for svm_window_scheduler: a frame-position reference model fills
// expected queues that a negedge monitor drains whenever the DUT strobes an output.
module tb_svm_window_scheduler;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int WW = 3;
  localparam int WH = 2;
  localparam int DW = 32;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int WINS_PER_FRAME = (H - WW + 1) * (V - WH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cell_valid = 1'b0;
  logic          cell_sof = 1'b0;
  logic [DW-1:0] cell_data = '0;
  logic [DW-1:0] dl_din;
  logic          dl_en;
  logic          dl_rst;
  logic          win_valid;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          frame_done;
  logic          sync_err;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expected queues: {due cycle, payload}
  logic [63:0] dl_q[$];
  logic [63:0] win_q[$];
  logic [63:0] sync_q[$];

  // Reference model: frame membership, cell index, cycles left in FLUSH/CLEAR
  bit in_frame = 1'b0;
  int blk = 0;
  int k = 0;
  int wcount = 0;
  logic [63:0] mon_e;

  svm_window_scheduler #(
    .H_SIZE(H), .V_SIZE(V), .WIN_W(WW), .WIN_H(WH), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .cell_valid(cell_valid), .cell_sof(cell_sof),
    .cell_data(cell_data), .dl_din(dl_din), .dl_en(dl_en), .dl_rst(dl_rst),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
    .frame_done(frame_done), .sync_err(sync_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void flag(input string nm, input int got, input int req);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, got, req, cyc);
  endfunction

  function automatic void accept_cell(input logic [DW-1:0] d);
    int col, row;
    col = k % H;
    row = k / H;
    dl_q.push_back({32'(cyc + 1), d});
    if (col >= WW - 1 && row >= WH - 1)
      win_q.push_back({32'(cyc + 2),
                       32'({XW'(col - (WW - 1)), YW'(row - (WH - 1)), (k == H * V - 1)})});
    k++;
    if (k == H * V) begin
      in_frame = 1'b0;
      blk = 2;
    end
  endfunction

  function automatic void model(input logic v, input logic s, input logic [DW-1:0] d);
    if (blk > 0) blk--;
    else if (!in_frame) begin
      if (v && s) begin
        in_frame = 1'b1;
        k = 0;
        accept_cell(d);
      end
    end else if (v && s) begin
      in_frame = 1'b0;
      blk = 1;
      sync_q.push_back(64'(cyc + 1));
    end else if (v) accept_cell(d);
  endfunction

  // Driver: called at posedge+1, presents one cycle of input
  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    chk("busy", 64'(busy), 64'(in_frame || blk > 0));
    chk("dl_rst", 64'(dl_rst), 64'(blk == 1));
    cell_valid = v;
    cell_sof = s;
    cell_data = d;
    if (!rst) model(v, s, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic send_frame(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap) step(1'b0, 1'($urandom_range(1)), $urandom);
      step(1'b1, (i == 0), $urandom);
    end
  endtask

  function automatic void check_zero();
    chk("rst_dl_en", 64'(dl_en), 0);
    chk("rst_dl_din", 64'(dl_din), 0);
    chk("rst_dl_rst", 64'(dl_rst), 0);
    chk("rst_win_valid", 64'(win_valid), 0);
    chk("rst_win_xy", 64'({win_x, win_y}), 0);
    chk("rst_frame_done", 64'(frame_done), 0);
    chk("rst_sync_err", 64'(sync_err), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_state", 64'(dbg_state), 0);
  endfunction

  // Asynchronous reset asserted between clock edges
  task automatic async_reset();
    #2;
    rst = 1'b1;
    cell_valid = 1'b0;
    #1;
    check_zero();
    dl_q.delete();
    win_q.delete();
    sync_q.delete();
    in_frame = 1'b0;
    blk = 0;
    k = 0;
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (dl_en) begin
        if (dl_q.size() == 0) flag("dl_en_unexpected", 1, 0);
        else begin
          mon_e = dl_q.pop_front();
          chk("dl_cycle", 64'(cyc), 64'(mon_e[63:32]));
          chk("dl_din", 64'(dl_din), 64'(mon_e[31:0]));
        end
      end else if (dl_q.size() > 0 && int'(dl_q[0][63:32]) <= cyc) begin
        flag("dl_en_missing", 0, 1);
        void'(dl_q.pop_front());
      end

      if (win_valid) begin
        if (win_x == '0 && win_y == '0) wcount = 1;
        else wcount++;
        if (win_q.size() == 0) flag("win_unexpected", 1, 0);
        else begin
          mon_e = win_q.pop_front();
          chk("win_cycle", 64'(cyc), 64'(mon_e[63:32]));
          chk("win_xy_done", 64'({win_x, win_y, frame_done}), 64'(mon_e[31:0]));
        end
        if (frame_done) chk("win_count", 64'(wcount), 64'(WINS_PER_FRAME));
      end else begin
        if (frame_done) flag("frame_done_alone", 1, 0);
        if (win_q.size() > 0 && int'(win_q[0][63:32]) <= cyc) begin
          flag("win_missing", 0, 1);
          void'(win_q.pop_front());
        end
      end

      if (sync_err) begin
        if (sync_q.size() == 0) flag("sync_err_unexpected", 1, 0);
        else begin
          mon_e = sync_q.pop_front();
          chk("sync_cycle", 64'(cyc), 64'(mon_e[63:32] == 0 ? mon_e[31:0] : mon_e));
        end
      end else if (sync_q.size() > 0 && int'(sync_q[0]) <= cyc) begin
        flag("sync_err_missing", 0, 1);
        void'(sync_q.pop_front());
      end
    end
  end

  // Scenario sequence
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero();
    rst = 1'b0;
    idle(2);

    send_frame(32, 0);          // contiguous
    idle(4);
    send_frame(32, 50);         // random gaps
    idle(4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, $urandom);  // pre-sof cells
    send_frame(32, 0);
    idle(4);

    send_frame(13, 0);          // mid-frame sof at cell index 13
    step(1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, '0);
    send_frame(32, 30);
    idle(4);

    send_frame(32, 0);          // back-to-back: sof at t+1 dropped, t+3 accepted
    step(1'b1, 1'b1, $urandom);
    step(1'b0, 1'b0, '0);
    send_frame(32, 0);
    idle(4);

    send_frame(20, 20);         // async reset mid-frame
    async_reset();
    idle(1);
    send_frame(32, 20);
    idle(4);

    for (int f = 0; f < 2; f++) begin
      send_frame(32, 30);
      idle($urandom_range(4, 1));
    end
    idle(10);

    chk("dl_q_drained", 64'(dl_q.size()), 0);
    chk("win_q_drained", 64'(win_q.size()), 0);
    chk("sync_q_drained", 64'(sync_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
